// File: rtl/mbist_addr_gen.sv
// MBIST address sequencer: sweeps a [lo,hi] window up or down by a fixed step.
// Optional macro MBIST_ADDR_GEN_WINDOW_CHECK_EN rejects starts with lo > hi via an err pulse.
module mbist_addr_gen #(
    parameter int ADDR_W = 10,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              u_d,
    input  logic [ADDR_W-1:0] lo,
    input  logic [ADDR_W-1:0] hi,
    input  logic [STEP_W-1:0] step,
    input  logic              adv,
    input  logic              abort,
    output logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic              last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

`ifdef MBIST_ADDR_GEN_WINDOW_CHECK_EN
    localparam logic WIN_CHECK = 1'b1;
`else
    localparam logic WIN_CHECK = 1'b0;
`endif

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [ADDR_W-1:0] lo_q,    lo_d;
    logic [ADDR_W-1:0] hi_q,    hi_d;
    logic [STEP_W-1:0] step_q,  step_d;
    logic              dir_q,   dir_d;
    logic              err_q,   err_d;

    logic [STEP_W-1:0] step_eff;
    logic [ADDR_W:0]   step_ext;
    logic [ADDR_W:0]   up_sum;
    logic [ADDR_W:0]   dn_floor;
    logic              at_last;
    logic              start_ok;

    assign step_eff = (step == '0) ? STEP_W'(1) : step;
    assign step_ext = {{(ADDR_W + 1 - STEP_W){1'b0}}, step_q};

    // Bounds compared one bit wider so the next address can never wrap.
    assign up_sum   = {1'b0, addr_q} + step_ext;
    assign dn_floor = {1'b0, lo_q} + step_ext;
    assign at_last  = dir_q ? (up_sum > {1'b0, hi_q})
                            : ({1'b0, addr_q} < dn_floor);

    assign start_ok = start && !abort;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        step_d  = step_q;
        dir_d   = dir_q;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    if (WIN_CHECK && (lo > hi)) begin
                        err_d = 1'b1;
                    end else begin
                        lo_d    = lo;
                        hi_d    = hi;
                        step_d  = step_eff;
                        dir_d   = u_d;
                        addr_d  = u_d ? lo : hi;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (adv) begin
                    if (at_last) begin
                        state_d = ST_DONE;
                    end else if (dir_q) begin
                        addr_d = addr_q + step_ext[ADDR_W-1:0];
                    end else begin
                        addr_d = addr_q - step_ext[ADDR_W-1:0];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            step_q  <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    assign addr  = addr_q;
    assign valid = (state_q == ST_RUN);
    assign last  = valid && at_last;
    assign busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done  = (state_q == ST_DONE);
    assign err   = err_q;

endmodule

// File: tb/tb_mbist_addr_gen.sv
// Self-checking bench for mbist_addr_gen: directed scenarios with literal
// expectations plus a randomized run compared against a sweep-list model.
module tb_mbist_addr_gen;

    localparam int ADDR_W = 10;
    localparam int STEP_W = 4;

`ifdef MBIST_ADDR_GEN_WINDOW_CHECK_EN
    localparam bit WIN_CHK = 1'b1;
`else
    localparam bit WIN_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, start, u_d, adv, abort;
    logic [ADDR_W-1:0] lo, hi;
    logic [STEP_W-1:0] step;
    logic [ADDR_W-1:0] addr;
    logic valid, last, busy, done, err;

    int checks = 0;
    int errors = 0;

    // Model: the whole sweep is precomputed as an address list on start.
    bit mActive, mDone, mErr;
    int mQ[$];
    int mIdx;
    int mAddr;
    int expSeq[$];

    always #5 clk = ~clk;

    mbist_addr_gen #(.ADDR_W(ADDR_W), .STEP_W(STEP_W)) dut (
        .clk(clk), .rst(rst), .start(start), .u_d(u_d), .lo(lo), .hi(hi),
        .step(step), .adv(adv), .abort(abort), .addr(addr), .valid(valid),
        .last(last), .busy(busy), .done(done), .err(err)
    );

    // Single comparison primitive; every check in the bench funnels through here
    task automatic compareVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Build the list of addresses a sweep must visit, from the window rules
    task automatic buildSweep();
        int s;
        int a;
        s = (step == 0) ? 1 : int'(step);
        mQ.delete();
        if (lo > hi) begin
            mQ.push_back(u_d ? int'(lo) : int'(hi));
        end else if (u_d) begin
            for (a = int'(lo); a <= int'(hi); a += s) mQ.push_back(a);
        end else begin
            for (a = int'(hi); a >= int'(lo); a -= s) mQ.push_back(a);
        end
    endtask

    // Advance the reference model by one rising edge using the current inputs
    task automatic modelStep();
        mErr = 1'b0;
        if (rst) begin
            mActive = 0; mDone = 0; mAddr = 0; mIdx = 0; mQ.delete();
        end else if ((mActive || mDone) && abort) begin
            mActive = 0; mDone = 0;
        end else if (mDone) begin
            mDone = 0;
        end else if (mActive) begin
            if (adv) begin
                if (mIdx == mQ.size() - 1) begin
                    mActive = 0; mDone = 1;
                end else begin
                    mIdx++;
                    mAddr = mQ[mIdx];
                end
            end
        end else if (start && !abort) begin
            if (WIN_CHK && (lo > hi)) begin
                mErr = 1'b1;
            end else begin
                buildSweep();
                mIdx = 0;
                mAddr = mQ[0];
                mActive = 1;
            end
        end
    endtask

    // Compare every DUT output against the model
    task automatic checkOutput();
        compareVal("m_addr",  int'(addr),  mAddr);
        compareVal("m_valid", int'(valid), int'(mActive));
        compareVal("m_last",  int'(last),  int'(mActive && (mIdx == mQ.size() - 1)));
        compareVal("m_busy",  int'(busy),  int'(mActive || mDone));
        compareVal("m_done",  int'(done),  int'(mDone));
        compareVal("m_err",   int'(err),   int'(mErr));
    endtask

    // One clock: model follows the edge, outputs are checked on the falling edge
    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    // Randomized inputs with window shapes biased toward the boundaries
    task automatic applyStimulus();
        int mode;
        int l;
        int h;
        rst   = ($urandom_range(0, 199) == 0);
        start = ($urandom_range(0, 3) == 0);
        abort = ($urandom_range(0, 49) == 0);
        adv   = ($urandom_range(0, 9) < 7);
        u_d   = 1'($urandom_range(0, 1));
        step  = STEP_W'($urandom_range(0, 15));
        mode  = $urandom_range(0, 9);
        if (mode == 0) begin
            l = $urandom_range(1, 1023);
            h = l - $urandom_range(1, l);
        end else if (mode == 1) begin
            l = $urandom_range(1000, 1023);
            h = 1023;
        end else if (mode == 2) begin
            l = 0;
            h = $urandom_range(0, 30);
        end else begin
            l = $urandom_range(0, 1000);
            h = l + $urandom_range(0, 23);
        end
        lo = ADDR_W'(l);
        hi = ADDR_W'(h);
    endtask

    // Directed sweep with adv held high, checked against a literal address list
    task automatic runSeq(input string name, input bit ud, input int l, input int h, input int s);
        u_d = ud; lo = ADDR_W'(l); hi = ADDR_W'(h); step = STEP_W'(s);
        adv = 1; abort = 0; start = 1;
        tick();
        start = 0;
        foreach (expSeq[i]) begin
            compareVal({name, "_valid"}, int'(valid), 1);
            compareVal({name, "_addr"},  int'(addr),  expSeq[i]);
            compareVal({name, "_last"},  int'(last),  int'(i == expSeq.size() - 1));
            tick();
        end
        compareVal({name, "_done"},  int'(done),  1);
        compareVal({name, "_valid0"}, int'(valid), 0);
        tick();
        compareVal({name, "_busy0"}, int'(busy), 0);
        compareVal({name, "_done0"}, int'(done), 0);
    endtask

    initial begin
        rst = 1; start = 0; u_d = 0; adv = 0; abort = 0; lo = '0; hi = '0; step = '0;
        mActive = 0; mDone = 0; mErr = 0; mIdx = 0; mAddr = 0;

        // Reset state
        tick();
        tick();
        compareVal("rst_addr",  int'(addr),  0);
        compareVal("rst_valid", int'(valid), 0);
        compareVal("rst_busy",  int'(busy),  0);
        compareVal("rst_err",   int'(err),   0);
        rst = 0;
        tick();

        // Basic up and down sweeps, plus a single-address window
        expSeq = {0, 3, 6, 9};
        runSeq("up3", 1, 0, 9, 3);
        expSeq = {10, 6, 2};
        runSeq("dn4", 0, 2, 10, 4);
        expSeq = {7};
        runSeq("single", 0, 7, 7, 5);

        // Top of address space with step 0 and adv toggling
        u_d = 1; lo = 10'd1020; hi = 10'd1023; step = 0; adv = 0; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 4; i++) begin
            compareVal("top_addr", int'(addr), 1020 + i);
            compareVal("top_last", int'(last), int'(i == 3));
            adv = 0;
            tick();
            compareVal("top_hold", int'(addr), 1020 + i);
            adv = 1;
            tick();
        end
        compareVal("top_done", int'(done), 1);
        compareVal("top_nowrap", int'(addr), 1023);
        adv = 0;
        tick();

        // Abort at address 6 with adv and start also high
        u_d = 1; lo = 0; hi = 30; step = 3; adv = 1; start = 1;
        tick();
        start = 0;
        tick();
        tick();
        compareVal("abort_at", int'(addr), 6);
        abort = 1; start = 1;
        tick();
        compareVal("abort_valid", int'(valid), 0);
        compareVal("abort_busy",  int'(busy),  0);
        compareVal("abort_done",  int'(done),  0);
        abort = 0; start = 0;
        tick();
        compareVal("abort_nodone", int'(done), 0);
        expSeq = {4, 5};
        runSeq("restart", 1, 4, 5, 1);

        // Inverted window
        if (WIN_CHK) begin
            u_d = 1; lo = 5; hi = 3; step = 2; adv = 1; start = 1;
            tick();
            start = 0;
            compareVal("inv_err",   int'(err),   1);
            compareVal("inv_valid", int'(valid), 0);
            tick();
            compareVal("inv_err0",  int'(err),   0);
            compareVal("inv_busy",  int'(busy),  0);
        end else begin
            expSeq = {5};
            runSeq("inv_up", 1, 5, 3, 2);
            expSeq = {3};
            runSeq("inv_dn", 0, 5, 3, 2);
        end

        // Reset mid-sweep; start held during the sweep must be ignored
        u_d = 1; lo = 0; hi = 20; step = 1; adv = 1; start = 1;
        tick();
        lo = 100; hi = 200; u_d = 0;
        for (int i = 0; i < 4; i++) begin
            compareVal("busy_start_addr", int'(addr), i);
            if (i < 3) tick();
        end
        rst = 1;
        tick();
        compareVal("mid_rst_addr",  int'(addr),  0);
        compareVal("mid_rst_valid", int'(valid), 0);
        compareVal("mid_rst_busy",  int'(busy),  0);
        compareVal("mid_rst_done",  int'(done),  0);
        compareVal("mid_rst_last",  int'(last),  0);
        rst = 0; start = 0;
        tick();

        // Randomized run against the model
        for (int c = 0; c < 4000; c++) begin
            applyStimulus();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mbist_addr_gen.md
MBIST_ADDR_GEN -- requirements
Module: mbist_addr_gen

Interface
REQ-001 Parameter ADDR_W, default 10, address width in bits (>=2).
REQ-002 Parameter STEP_W, default 4, step width in bits (1..ADDR_W).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port start  input  1  one-cycle request to begin a sweep.
REQ-006 Port u_d  input  1  sweep direction, 1 = up (lo->hi), 0 = down (hi->lo); sampled at accepted start.
REQ-007 Port lo  input  ADDR_W  lower window bound; sampled at accepted start.
REQ-008 Port hi  input  ADDR_W  upper window bound; sampled at accepted start.
REQ-009 Port step  input  STEP_W  address increment; sampled at accepted start; 0 treated as 1.
REQ-010 Port adv  input  1  consumer accepts current addr; advances the sweep.
REQ-011 Port abort  input  1  terminate sweep immediately, no done pulse.
REQ-012 Port addr  output  ADDR_W  current address, registered.
REQ-013 Port valid  output  1  addr is a legal sweep address.
REQ-014 Port last  output  1  current addr is the final address of the sweep (only with valid).
REQ-015 Port busy  output  1  sweep in progress (RUN or DONE).
REQ-016 Port done  output  1  one-cycle pulse after the final address is accepted.
REQ-017 Port err  output  1  one-cycle illegal-window pulse (see Configuration).

Function
REQ-018 States IDLE, RUN, DONE; valid=1 only in RUN; busy=1 in RUN and DONE; done=1 only in DONE.
REQ-019 IDLE + start (no abort): latch u_d, lo, hi, step_eff; addr <= lo if up else hi; enter RUN; valid high the following cycle (latency 1).
REQ-020 start while busy is ignored; latched configuration is unaffected by input changes during a sweep.
REQ-021 RUN: addr holds while adv=0; adv=1 and last=0 -> addr <= addr+step_eff (up) or addr-step_eff (down).
REQ-022 last (up) = (addr + step_eff > hi), evaluated at ADDR_W+1 bits; no wrap past 2^ADDR_W-1.
REQ-023 last (down) = (addr < lo + step_eff), evaluated at ADDR_W+1 bits; no wrap below 0.
REQ-024 RUN + adv + last -> DONE; DONE lasts exactly one cycle then IDLE; addr holds final value.
REQ-025 abort in RUN or DONE -> IDLE next cycle, done not asserted; abort has priority over adv and start.
REQ-026 lo == hi: single-address sweep, last=1 on first valid cycle.
REQ-027 Window never overshot: final addr is the last lo+k*step_eff <= hi (up) or hi-k*step_eff >= lo (down).

Reset
REQ-028 rst=1 at a rising edge: state IDLE, addr=0, valid=0, last=0, busy=0, done=0, err=0, latched config=0.
REQ-029 rst has priority over start, adv, abort; reset mid-sweep discards the sweep without done.

Configuration
REQ-030 Macro MBIST_ADDR_GEN_WINDOW_CHECK_EN defined: start in IDLE with lo > hi -> err=1 for one cycle, state stays IDLE, no sweep.
REQ-031 Macro undefined: err tied 0; start with lo > hi runs a single-address sweep at lo (up) or hi (down), last=1 immediately.

Verification
REQ-032 ADDR_W=10, lo=0, hi=9, step=3, u_d=1, adv held 1 -> addr 0,3,6,9; last with 9; done one cycle after 9 accepted.
REQ-033 lo=2, hi=10, step=4, u_d=0, adv held 1 -> addr 10,6,2; last with 2; then done, busy drops following cycle.
REQ-034 lo=1020, hi=1023, step=0 (->1), up, adv toggled 1/0 -> addr 1020..1023 each held while adv=0, no wrap to 0.
REQ-035 Sweep running, abort with adv=1 at addr 6 -> IDLE next cycle, valid=0, done never pulses; start re-accepted after.
REQ-036 start with lo=5, hi=3: with MBIST_ADDR_GEN_WINDOW_CHECK_EN -> err pulse, valid stays 0; without -> single addr 5, last=1, done.
REQ-037 rst asserted mid-sweep at addr 3 -> next cycle all outputs 0; start during busy ignored (addr sequence unchanged).
